z16_decode_stage: RTL and testbench
===================================

Name: z16_decode_stage

Overview:
Registered, parametrised Z16 decode pipeline stage. It sits between fetch and execute and accepts 16-bit Z16 instructions over a valid/ready handshake. Each instruction is decoded into opcode, register addresses, a sign-extended immediate of width XLEN and control signals. A register scoreboard holds issue back until RAW and WAW hazards clear through writeback, and a stall-cycle counter reports how long issue was held.

Parameters:
XLEN, 16, immediate/datapath width; legal values are 16 or greater; the immediate is sign-extended to XLEN.
NUM_REGS, 16, scoreboard entries; fixed at 16 by the 4-bit register fields; any other value is an elaboration error.
STALL_CNT_W, 16, width of the stall counter.

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_valid  in  1  upstream instruction valid
o_ready  out  1  stage can accept
i_instr  in  16  instruction word
o_valid  out  1  decoded instruction valid and hazard-free
i_ready  in  1  execute accepts
o_opcode  out  4  instr[3:0]
o_rd_addr  out  4  instr[7:4]
o_rs1_addr  out  4  source 1 address
o_rs2_addr  out  4  source 2 address
o_imm  out  XLEN  sign-extended immediate
o_rd_wen  out  1  destination write enable
o_mem_wen  out  1  store enable
o_alu_ctrl  out  4  ALU operation
i_wb_valid  in  1  writeback retires a register
i_wb_addr  in  4  retired register
i_flush  in  1  drop the held instruction
o_busy_mask  out  NUM_REGS  scoreboard state
o_stall_cnt  out  STALL_CNT_W  saturating hazard-stall cycles

Behaviour:
- Reset (async, i_rst_n low): held-valid=0, scoreboard=0, stall count=0, all decoded output registers=0; o_valid=0, o_ready=1.
- Decode (combinational on i_instr, captured on accept):
  - rs1: instr[7:4] for op 9; {2'b00,instr[5:4]} for op E/F; otherwise instr[11:8].
  - rs2: {2'b00,instr[7:6]} for op E/F; otherwise instr[15:12].
  - imm: op 9/E/F sign-extend instr[15:8]; op A/C/D sign-extend instr[15:12]; op B sign-extend instr[7:4]; otherwise 0.
  - rd_wen: op 0..A, C, D.
  - mem_wen: op B only.
  - alu_ctrl: the opcode for op 0..8, otherwise 0 (ADD).
- Source use: op 0..8, B, E, F use rs1 and rs2; op 9, A, D use rs1 only; op C uses neither.
- Hazard: held-valid and any used source, or rd when rd_wen is set, has its bit set in (scoreboard & ~wb_clear_mask). A writeback in the same cycle therefore releases the hazard that cycle.
- o_valid = held-valid & ~hazard.
- Issue happens when o_valid & i_ready. On issue with rd_wen, set scoreboard[rd].
- Writeback: i_wb_valid clears scoreboard[i_wb_addr]. If set and clear hit the same register in one cycle, set wins.
- Accept happens when i_valid & o_ready. Without the skid buffer, o_ready = ~held-valid | issue (combinational). Accept and issue in the same cycle give 1-instruction/cycle throughput; decode latency is 1 cycle.
- Held fields stay stable while o_valid=0 or i_ready=0.
- i_flush clears held-valid next edge and has priority over accept in the same cycle. An issue in the flush cycle still sets the scoreboard. The scoreboard is never flushed.
- o_stall_cnt increments each cycle in which held-valid & hazard is true, and saturates at all-ones.

Optional Feature:
Z16_DECODE_SKID_EN
- Defined: a 1-entry skid buffer is added, o_ready becomes a flop output (= skid empty), and throughput stays 1/cycle. Flush clears both entries.
- Undefined: no skid buffer; o_ready is combinational as above.

Decomposition:
- Package z16_pkg holds:
  - opcode localparams (OP_ADDI=9, OP_LOAD=A, OP_STORE=B, OP_JAL=C, OP_JRL=D, OP_BR0=E, OP_BR1=F);
  - ALU_ADD=0;
  - a decoded-instruction struct typedef;
  - functions for source use and rd_wen.
- One sub-module, z16_scoreboard: set/clear/mask logic producing o_busy_mask.

Test Plan:
- Reset, then i_instr=16'h2310 (op 0, rd 1, rs1 3, rs2 2) -> next cycle o_valid=1, o_alu_ctrl=0, o_rd_wen=1, o_busy_mask=0.
- XLEN=32, i_instr=16'hFF19 -> o_imm=32'hFFFF_FFFF, o_rs1_addr=1, o_rd_addr=1.
- Issue 16'h2310, then 16'h4150 (reads r1) -> o_valid=0 and o_stall_cnt increments each cycle. Pulse i_wb_valid with addr 1 -> o_valid=1 in that same cycle.
- i_ready=0 for 3 cycles with i_valid=1 -> fields are held, no second accept (o_ready=0, or 1 only until the skid entry fills).
- Same-cycle issue writing r5 and i_wb_valid on r5 -> o_busy_mask[5]=1. i_flush while stalled -> o_valid=0 next cycle and the scoreboard is unchanged.
- Force 2^STALL_CNT_W stall cycles with STALL_CNT_W=4 -> o_stall_cnt holds 4'hF.

Source files
------------

// File: rtl/z16_pkg.sv
// Shared Z16 decode definitions: opcode encodings, the decoded-instruction
// payload and the field-extraction helpers used by the decode stage.
package z16_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned REG_AW  = 4;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned IMM8_W  = 8;

  localparam logic [OP_W-1:0] OP_ALU_MAX = 4'h8;
  localparam logic [OP_W-1:0] OP_ADDI    = 4'h9;
  localparam logic [OP_W-1:0] OP_LOAD    = 4'hA;
  localparam logic [OP_W-1:0] OP_STORE   = 4'hB;
  localparam logic [OP_W-1:0] OP_JAL     = 4'hC;
  localparam logic [OP_W-1:0] OP_JRL     = 4'hD;
  localparam logic [OP_W-1:0] OP_BR0     = 4'hE;
  localparam logic [OP_W-1:0] OP_BR1     = 4'hF;

  localparam logic [OP_W-1:0] ALU_ADD = 4'h0;

  // Immediates never exceed 8 source bits, so they travel pre-extended to
  // 8 bits and are widened to XLEN only at the stage output.
  typedef struct packed {
    logic [OP_W-1:0]   opcode;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [IMM8_W-1:0] imm8;
    logic              rd_wen;
    logic              mem_wen;
    logic [OP_W-1:0]   alu_ctrl;
    logic              use_rs1;
    logic              use_rs2;
  } z16_dec_t;

  function automatic logic z16_uses_rs1(input logic [OP_W-1:0] op);
    return op != OP_JAL;
  endfunction

  function automatic logic z16_uses_rs2(input logic [OP_W-1:0] op);
    return (op <= OP_ALU_MAX) || (op == OP_STORE) || (op == OP_BR0) || (op == OP_BR1);
  endfunction

  function automatic logic z16_rd_wen(input logic [OP_W-1:0] op);
    return (op <= OP_LOAD) || (op == OP_JAL) || (op == OP_JRL);
  endfunction

  function automatic z16_dec_t z16_decode(input logic [INSTR_W-1:0] instr);
    z16_dec_t d;
    d          = '0;
    d.opcode   = instr[3:0];
    d.rd       = instr[7:4];
    d.rs1      = instr[11:8];
    d.rs2      = instr[15:12];
    d.rd_wen   = z16_rd_wen(instr[3:0]);
    d.mem_wen  = (instr[3:0] == OP_STORE);
    d.alu_ctrl = (instr[3:0] <= OP_ALU_MAX) ? instr[3:0] : ALU_ADD;
    d.use_rs1  = z16_uses_rs1(instr[3:0]);
    d.use_rs2  = z16_uses_rs2(instr[3:0]);
    case (instr[3:0])
      OP_ADDI: begin
        d.rs1  = instr[7:4];
        d.imm8 = instr[15:8];
      end
      OP_LOAD, OP_JAL, OP_JRL: d.imm8 = {{4{instr[15]}}, instr[15:12]};
      OP_STORE:                d.imm8 = {{4{instr[7]}}, instr[7:4]};
      OP_BR0, OP_BR1: begin
        d.rs1  = {2'b00, instr[5:4]};
        d.rs2  = {2'b00, instr[7:6]};
        d.imm8 = instr[15:8];
      end
      default: d.imm8 = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/z16_scoreboard.sv
// Register busy tracker: issue sets a destination bit, writeback clears one;
// a set and clear of the same register in one cycle leaves it busy.
module z16_scoreboard
  import z16_pkg::*;
#(
  parameter int unsigned NUM_REGS = 16
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_set_en,
  input  logic [REG_AW-1:0]   i_set_addr,
  input  logic                i_clr_en,
  input  logic [REG_AW-1:0]   i_clr_addr,
  output logic [NUM_REGS-1:0] o_busy_mask,
  output logic [NUM_REGS-1:0] o_busy_eff_c
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [NUM_REGS-1:0] set_mask_c;
  logic [NUM_REGS-1:0] clr_mask_c;

  always_comb begin
    set_mask_c   = i_set_en ? (NUM_REGS'(1) << i_set_addr) : '0;
    clr_mask_c   = i_clr_en ? (NUM_REGS'(1) << i_clr_addr) : '0;
    // Hazard view already excludes the register retiring this cycle.
    o_busy_eff_c = busy_q & ~clr_mask_c;
    busy_d       = o_busy_eff_c | set_mask_c;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) busy_q <= '0;
    else          busy_q <= busy_d;
  end

  assign o_busy_mask = busy_q;

endmodule

// File: rtl/z16_decode_stage.sv
// Z16 decode stage with scoreboard hazard hold and saturating stall counter.
// Define Z16_DECODE_SKID_EN for a 1-entry skid buffer with a registered o_ready.
module z16_decode_stage
  import z16_pkg::*;
#(
  parameter int unsigned XLEN        = 16,
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [INSTR_W-1:0]     i_instr,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [OP_W-1:0]        o_opcode,
  output logic [REG_AW-1:0]      o_rd_addr,
  output logic [REG_AW-1:0]      o_rs1_addr,
  output logic [REG_AW-1:0]      o_rs2_addr,
  output logic [XLEN-1:0]        o_imm,
  output logic                   o_rd_wen,
  output logic                   o_mem_wen,
  output logic [OP_W-1:0]        o_alu_ctrl,
  input  logic                   i_wb_valid,
  input  logic [REG_AW-1:0]      i_wb_addr,
  input  logic                   i_flush,
  output logic [NUM_REGS-1:0]    o_busy_mask,
  output logic [STALL_CNT_W-1:0] o_stall_cnt
);

  if (NUM_REGS != 16) begin : g_num_regs_chk
    $error("z16_decode_stage: NUM_REGS must be 16");
  end
  if (XLEN < 16) begin : g_xlen_chk
    $error("z16_decode_stage: XLEN must be at least 16");
  end

  z16_dec_t               dec_in_c;
  z16_dec_t               held_q, held_d;
  logic                   held_valid_q, held_valid_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [NUM_REGS-1:0]    busy_eff_c;
  logic                   hazard_c;
  logic                   issue_c;
  logic                   accept_c;
  logic                   main_free_c;

`ifdef Z16_DECODE_SKID_EN
  z16_dec_t skid_q, skid_d;
  logic     skid_valid_q, skid_valid_d;
`endif

  assign dec_in_c = z16_decode(i_instr);

  z16_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_set_en     (issue_c & held_q.rd_wen),
    .i_set_addr   (held_q.rd),
    .i_clr_en     (i_wb_valid),
    .i_clr_addr   (i_wb_addr),
    .o_busy_mask  (o_busy_mask),
    .o_busy_eff_c (busy_eff_c)
  );

  // Hazard, handshake and stall-count evaluation.
  always_comb begin
    hazard_c = held_valid_q &
               ((held_q.use_rs1 & busy_eff_c[held_q.rs1]) |
                (held_q.use_rs2 & busy_eff_c[held_q.rs2]) |
                (held_q.rd_wen  & busy_eff_c[held_q.rd]));
    o_valid     = held_valid_q & ~hazard_c;
    issue_c     = o_valid & i_ready;
    main_free_c = ~held_valid_q | issue_c;
`ifdef Z16_DECODE_SKID_EN
    o_ready = ~skid_valid_q;
`else
    o_ready = main_free_c;
`endif
    accept_c    = i_valid & o_ready & ~i_flush;
    stall_cnt_d = stall_cnt_q;
    if (hazard_c && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
  end

  // Held-instruction (and skid) next state; flush drops everything queued.
  always_comb begin
    held_d       = held_q;
    held_valid_d = held_valid_q;
`ifdef Z16_DECODE_SKID_EN
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (main_free_c) begin
      if (skid_valid_q) begin
        held_d       = skid_q;
        held_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept_c) begin
        held_d       = dec_in_c;
        held_valid_d = 1'b1;
      end else begin
        held_valid_d = 1'b0;
      end
    end else if (accept_c) begin
      skid_d       = dec_in_c;
      skid_valid_d = 1'b1;
    end
    if (i_flush) skid_valid_d = 1'b0;
`else
    if (accept_c) begin
      held_d       = dec_in_c;
      held_valid_d = 1'b1;
    end else if (issue_c) begin
      held_valid_d = 1'b0;
    end
`endif
    if (i_flush) held_valid_d = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      held_q       <= '0;
      held_valid_q <= 1'b0;
      stall_cnt_q  <= '0;
`ifdef Z16_DECODE_SKID_EN
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
`endif
    end else begin
      held_q       <= held_d;
      held_valid_q <= held_valid_d;
      stall_cnt_q  <= stall_cnt_d;
`ifdef Z16_DECODE_SKID_EN
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
`endif
    end
  end

  assign o_opcode    = held_q.opcode;
  assign o_rd_addr   = held_q.rd;
  assign o_rs1_addr  = held_q.rs1;
  assign o_rs2_addr  = held_q.rs2;
  assign o_imm       = {{(XLEN-IMM8_W){held_q.imm8[IMM8_W-1]}}, held_q.imm8};
  assign o_rd_wen    = held_q.rd_wen;
  assign o_mem_wen   = held_q.mem_wen;
  assign o_alu_ctrl  = held_q.alu_ctrl;
  assign o_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_z16_decode_stage.sv
// Scoreboard-driven bench for z16_decode_stage (XLEN=32, 4-bit stall counter).
module tb_z16_decode_stage;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 16;
  localparam int unsigned SCW  = 4;

  localparam logic [15:0] STREAM [6] = '{16'h21AB, 16'h85CE, 16'h7F3F,
                                         16'h9A2C, 16'h3D4D, 16'hE31A};

  logic            i_clk = 1'b0;
  logic            i_rst_n;
  logic            i_valid;
  logic            o_ready;
  logic [15:0]     i_instr;
  logic            o_valid;
  logic            i_ready;
  logic [3:0]      o_opcode;
  logic [3:0]      o_rd_addr;
  logic [3:0]      o_rs1_addr;
  logic [3:0]      o_rs2_addr;
  logic [XLEN-1:0] o_imm;
  logic            o_rd_wen;
  logic            o_mem_wen;
  logic [3:0]      o_alu_ctrl;
  logic            i_wb_valid;
  logic [3:0]      i_wb_addr;
  logic            i_flush;
  logic [NREG-1:0] o_busy_mask;
  logic [SCW-1:0]  o_stall_cnt;

  always #5 i_clk = ~i_clk;

  z16_decode_stage #(.XLEN(XLEN), .NUM_REGS(NREG), .STALL_CNT_W(SCW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_instr(i_instr), .o_valid(o_valid), .i_ready(i_ready), .o_opcode(o_opcode),
    .o_rd_addr(o_rd_addr), .o_rs1_addr(o_rs1_addr), .o_rs2_addr(o_rs2_addr),
    .o_imm(o_imm), .o_rd_wen(o_rd_wen), .o_mem_wen(o_mem_wen), .o_alu_ctrl(o_alu_ctrl),
    .i_wb_valid(i_wb_valid), .i_wb_addr(i_wb_addr), .i_flush(i_flush),
    .o_busy_mask(o_busy_mask), .o_stall_cnt(o_stall_cnt)
  );

  typedef struct packed {
    logic [15:0] regs;
    logic [31:0] imm;
    logic [5:0]  ctrl;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] sx4(input logic [3:0] v);
    return {{28{v[3]}}, v};
  endfunction

  // Reference decode written from the opcode table.
  function automatic exp_t model(input logic [15:0] ins);
    logic [3:0]  op, rd, rs1, rs2, alu;
    logic [31:0] imm;
    logic        wen, men;
    exp_t        e;
    op = ins[3:0]; rd = ins[7:4]; rs1 = ins[11:8]; rs2 = ins[15:12];
    imm = '0; wen = 1'b0; men = 1'b0; alu = 4'h0;
    case (op)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8: begin
        alu = op; wen = 1'b1;
      end
      4'h9: begin rs1 = ins[7:4]; imm = {{24{ins[15]}}, ins[15:8]}; wen = 1'b1; end
      4'hA, 4'hC, 4'hD: begin imm = sx4(ins[15:12]); wen = 1'b1; end
      4'hB: begin imm = sx4(ins[7:4]); men = 1'b1; end
      default: begin
        rs1 = {2'b00, ins[5:4]}; rs2 = {2'b00, ins[7:6]};
        imm = {{24{ins[15]}}, ins[15:8]};
      end
    endcase
    e.regs = {rs2, rs1, rd, op};
    e.imm  = imm;
    e.ctrl = {wen, men, alu};
    return e;
  endfunction

  // Issue side: compare against the oldest accepted instruction.
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_issue", 64'(o_opcode), 64'hDEAD);
        end else begin
          mon_e = exp_q.pop_front();
          check("issue_regs", {o_rs2_addr, o_rs1_addr, o_rd_addr, o_opcode}, mon_e.regs);
          check("issue_imm", o_imm, mon_e.imm);
          check("issue_ctrl", {o_rd_wen, o_mem_wen, o_alu_ctrl}, mon_e.ctrl);
        end
      end
      if (i_flush) exp_q.delete();
      if (i_valid && o_ready && !i_flush) exp_q.push_back(model(i_instr));
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wb(input logic [3:0] a);
    i_wb_valid = 1'b1; i_wb_addr = a;
    step();
    i_wb_valid = 1'b0;
  endtask

  initial begin
    i_rst_n = 1'b0; i_valid = 1'b0; i_instr = '0; i_ready = 1'b1;
    i_wb_valid = 1'b0; i_wb_addr = '0; i_flush = 1'b0;
    repeat (2) step();
    check("rst_valid", o_valid, 0);
    check("rst_ready", o_ready, 1);
    check("rst_busy", o_busy_mask, 0);
    check("rst_stall", o_stall_cnt, 0);
    check("rst_imm", o_imm, 0);
    check("rst_fields", {o_opcode, o_rd_addr, o_rs1_addr, o_rs2_addr, o_rd_wen, o_mem_wen, o_alu_ctrl}, 0);
    i_rst_n = 1'b1;
    step();

    // Back-to-back stream of mixed formats, no hazards.
    for (int i = 0; i < 6; i++) begin
      i_valid = 1'b1; i_instr = STREAM[i];
      #1 check("stream_ready", o_ready, 1);
      step();
    end
    i_valid = 1'b0;
    step();
    check("stream_busy", o_busy_mask, 16'h0016);
    wb(4'd1); wb(4'd2); wb(4'd4);
    check("stream_busy_clr", o_busy_mask, 0);

    // Basic ALU op.
    i_valid = 1'b1; i_instr = 16'h2310; step(); i_valid = 1'b0;
    check("t1_valid", o_valid, 1);
    check("t1_alu", o_alu_ctrl, 0);
    check("t1_rd_wen", o_rd_wen, 1);
    check("t1_busy", o_busy_mask, 0);
    step();
    check("t1_busy_set", o_busy_mask, 16'h0002);

    // RAW on r1, released by same-cycle writeback.
    i_valid = 1'b1; i_instr = 16'h4150; step(); i_valid = 1'b0;
    check("raw_valid", o_valid, 0);
`ifndef Z16_DECODE_SKID_EN
    check("raw_ready", o_ready, 0);
`endif
    step(); step();
    check("raw_stall", o_stall_cnt, 2);
    i_wb_valid = 1'b1; i_wb_addr = 4'd1;
    #1 check("raw_wb_valid", o_valid, 1);
    step(); i_wb_valid = 1'b0;
    check("raw_busy", o_busy_mask, 16'h0020);
    check("raw_stall_hold", o_stall_cnt, 2);

    // Wide immediate held while execute back-pressures.
    i_valid = 1'b1; i_instr = 16'hFF19; i_ready = 1'b0; step();
    i_instr = 16'h0001;
    for (int i = 0; i < 3; i++) begin
      check("hold_valid", o_valid, 1);
      check("hold_imm", o_imm, 32'hFFFF_FFFF);
      check("hold_rs1", o_rs1_addr, 1);
      check("hold_rd", o_rd_addr, 1);
`ifndef Z16_DECODE_SKID_EN
      check("hold_ready", o_ready, 0);
`endif
      step();
    end
    i_ready = 1'b1; step(); i_valid = 1'b0;
    step();
    check("hold_busy", o_busy_mask, 16'h0023);

    // WAW on r5; issue and writeback of r5 in the same cycle keeps it busy.
    i_valid = 1'b1; i_instr = 16'h6657; step(); i_valid = 1'b0;
    check("waw_valid", o_valid, 0);
    step();
    check("waw_stall", o_stall_cnt, 3);
    i_wb_valid = 1'b1; i_wb_addr = 4'd5;
    #1 check("waw_wb_valid", o_valid, 1);
    step(); i_wb_valid = 1'b0;
    check("setwin_bit5", o_busy_mask[5], 1);
    check("setwin_mask", o_busy_mask, 16'h0023);

    // Flush a stalled instruction; scoreboard untouched.
    i_valid = 1'b1; i_instr = 16'h1150; step(); i_valid = 1'b0;
    check("fl_pre_valid", o_valid, 0);
    i_flush = 1'b1; step(); i_flush = 1'b0;
    check("fl_valid", o_valid, 0);
    check("fl_busy", o_busy_mask, 16'h0023);
    check("fl_ready", o_ready, 1);
    wb(4'd1); wb(4'd5);
    check("fl_no_issue", o_valid, 0);
    check("fl_busy_after", o_busy_mask, 16'h0001);

    // Long stall saturates the 4-bit counter.
    i_valid = 1'b1; i_instr = 16'h0000; step(); i_valid = 1'b0;
    repeat (20) step();
    check("sat_cnt", o_stall_cnt, 4'hF);
    step();
    check("sat_hold", o_stall_cnt, 4'hF);
    i_wb_valid = 1'b1; i_wb_addr = 4'd0;
    #1 check("sat_release", o_valid, 1);
    step(); i_wb_valid = 1'b0;
    check("sat_busy", o_busy_mask, 16'h0001);
    check("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
